// File: rtl/wvb_reader_pkg.sv
// wvb_reader_pkg: shared types and constants for the waveform-buffer reader
package wvb_reader_pkg;
  localparam int L_WIDTH_MDOM_WVB_HDR_BUNDLE_4 = 80;
  localparam int L_RD_LATENCY = 2;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } rd_state_t;
  typedef struct packed {
    logic [47:0] evt_ltc;
    logic [11:0] start_addr;
    logic [11:0] stop_addr;
    logic [1:0]  trig_src;
    logic        cnst_run;
    logic [4:0]  pre_conf;
  } wvb_hdr_t;
endpackage

// File: rtl/mDOM_wvb_hdr_bundle_4_fan_out.sv
// mDOM_wvb_hdr_bundle_4_fan_out: unpacks the flat event header bundle into its fields
//   hdr_bundle in  flat header as carried by the header FIFO
//   hdr        out field view (evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf)
module mDOM_wvb_hdr_bundle_4_fan_out
  import wvb_reader_pkg::*;
(
  input  logic [L_WIDTH_MDOM_WVB_HDR_BUNDLE_4-1:0] hdr_bundle,
  output wvb_hdr_t                                 hdr
);
  assign hdr = hdr_bundle;
endmodule

// File: rtl/wvb_rd_skid_fifo.sv
// wvb_rd_skid_fifo: small show-ahead FIFO of sample words tagged with sop/eop
//   clk, rst                      clock, async active-high reset
//   wr_en, wr_data, wr_sop/eop    push side
//   rd_en, rd_data, rd_sop/eop    pop side; head is zero while empty
//   empty, count                  occupancy
module wvb_rd_skid_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 22
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [P_WIDTH-1:0]             wr_data,
  input  logic                           wr_sop,
  input  logic                           wr_eop,
  input  logic                           rd_en,
  output logic [P_WIDTH-1:0]             rd_data,
  output logic                           rd_sop,
  output logic                           rd_eop,
  output logic                           empty,
  output logic [$clog2(P_DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(P_DEPTH + 1);
  localparam int AW = $clog2(P_DEPTH);
  logic [P_WIDTH+1:0] mem [P_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && count < CW'(P_DEPTH);
  assign pop = rd_en && !empty;
  assign empty = count == '0;
  assign {rd_sop, rd_eop, rd_data} = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(P_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == AW'(P_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {wr_sop, wr_eop, wr_data};
endmodule

// File: rtl/wvb_reader.sv
// wvb_reader: pops event headers and streams each event's samples from the waveform buffer
//   rd_en                          readout permitted (sampled in IDLE only)
//   hdr_empty, hdr_data, hdr_rdreq show-ahead header FIFO
//   wvb_rd_addr, wvb_data          sample RAM, data 2 cycles after address
//   wvb_rddone                     one pulse per event, together with hdr_rdreq
//   dout_*                         ready/valid sample stream with sop/eop and latched header
//   busy                           event in progress
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_SKID_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]  dout_hdr,
  output logic [P_DATA_WIDTH-1:0] dout_data,
  output logic                    dout_valid,
  output logic                    dout_sop,
  output logic                    dout_eop,
  input  logic                    dout_ready,
  output logic                    busy
);
  localparam int CW = $clog2(P_SKID_DEPTH + 1);
  rd_state_t state, state_next;
  wvb_hdr_t hdr_f;
  logic [P_ADR_WIDTH-1:0] rd_ptr, remaining;
  logic first, issue, last_rd, skid_empty;
  logic [L_RD_LATENCY-1:0] pipe_v, pipe_sop, pipe_eop;
  logic [CW-1:0] skid_count;
  logic [CW:0] occupancy;
  mDOM_wvb_hdr_bundle_4_fan_out u_fan_out (
    .hdr_bundle(hdr_data),
    .hdr       (hdr_f)
  );
  // A read is issued only if the FIFO could still hold it when nothing drains
  // for the whole RAM latency: words already queued plus reads in flight plus this one.
  assign occupancy = {1'b0, skid_count} + (CW+1)'($countones(pipe_v));
  assign issue = state == S_READ && occupancy < (CW+1)'(P_SKID_DEPTH);
  assign last_rd = remaining == '0;
  assign wvb_rd_addr = rd_ptr;
  assign dout_valid = !skid_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = rd_en && !hdr_empty ? S_LOAD : S_IDLE;
      S_LOAD:  state_next = S_READ;
      S_READ:  state_next = issue && last_rd ? S_DRAIN : S_READ;
      S_DRAIN: state_next = skid_empty && pipe_v == '0 ? S_DONE : S_DRAIN;
      default: state_next = S_IDLE;
    endcase
  end
  // The header is popped in DONE, so hdr_data still shows this event's
  // stop_addr while wvb_rddone is high.
  always_comb begin
    busy = state != S_IDLE;
    wvb_rddone = state == S_DONE;
    hdr_rdreq = state == S_DONE;
  end
  // remaining counts reads left after the current one; wraps with the address space
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_hdr <= '0;
      rd_ptr <= '0;
      remaining <= '0;
      first <= 1'b0;
    end else if (state == S_LOAD) begin
      dout_hdr <= P_HDR_WIDTH'(hdr_f);
      rd_ptr <= P_ADR_WIDTH'(hdr_f.start_addr);
      remaining <= P_ADR_WIDTH'(hdr_f.stop_addr) - P_ADR_WIDTH'(hdr_f.start_addr);
      first <= 1'b1;
    end else if (issue) begin
      rd_ptr <= rd_ptr + 1'b1;
      remaining <= remaining - 1'b1;
      first <= 1'b0;
    end
  // Tags travel alongside each read so they meet the RAM word on arrival
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pipe_v <= '0;
      pipe_sop <= '0;
      pipe_eop <= '0;
    end else begin
      pipe_v <= {pipe_v[L_RD_LATENCY-2:0], issue};
      pipe_sop <= {pipe_sop[L_RD_LATENCY-2:0], first};
      pipe_eop <= {pipe_eop[L_RD_LATENCY-2:0], last_rd};
    end
  wvb_rd_skid_fifo #(
    .P_DEPTH(P_SKID_DEPTH),
    .P_WIDTH(P_DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (pipe_v[L_RD_LATENCY-1]),
    .wr_data(wvb_data),
    .wr_sop (pipe_sop[L_RD_LATENCY-1]),
    .wr_eop (pipe_eop[L_RD_LATENCY-1]),
    .rd_en  (dout_valid && dout_ready),
    .rd_data(dout_data),
    .rd_sop (dout_sop),
    .rd_eop (dout_eop),
    .empty  (skid_empty),
    .count  (skid_count)
  );
endmodule

// File: tb/tb_wvb_reader.sv
// tb_wvb_reader: randomized self-checking bench for wvb_reader against an event-level model
module tb_wvb_reader;
  localparam int AW = 12, DW = 22, HW = 80, SD = 4, N = 1 << AW;
  logic clk = 0, rst = 1, rd_en = 0, hdr_empty = 1, dout_ready = 1;
  logic hdr_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, busy;
  logic [HW-1:0] hdr_data = '0, dout_hdr;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_data = '0, dout_data, ram_q1;
  logic [DW-1:0] ram [N];
  typedef struct {
    int cyc;
    logic [HW-1:0] hdr;
    logic sop;
    logic eop;
    logic [DW-1:0] data;
  } word_t;
  word_t got[$], exp_q[$];
  logic [HW-1:0] hq[$], evt_hdrs[$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, max_skid = 0;
  bit rand_ready = 0, pop_pend = 0, saw_rdreq = 0;
  always #5 clk = ~clk;
  wvb_reader #(
    .P_ADR_WIDTH(AW),
    .P_DATA_WIDTH(DW),
    .P_HDR_WIDTH(HW),
    .P_SKID_DEPTH(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .hdr_empty(hdr_empty),
    .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq),
    .wvb_rd_addr(wvb_rd_addr),
    .wvb_data(wvb_data),
    .wvb_rddone(wvb_rddone),
    .dout_hdr(dout_hdr),
    .dout_data(dout_data),
    .dout_valid(dout_valid),
    .dout_sop(dout_sop),
    .dout_eop(dout_eop),
    .dout_ready(dout_ready),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask
  // sample RAM with two cycles of read latency
  always @(posedge clk) begin
    ram_q1 <= ram[wvb_rd_addr];
    wvb_data <= ram_q1;
  end
  // header FIFO model, ready driver and output monitor; all at the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (pop_pend) begin
      if (hq.size() > 0) hq.delete(0);
      pop_pend = 0;
    end
    hdr_empty = hq.size() == 0;
    hdr_data = hdr_empty ? '0 : hq[0];
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (dout_valid && dout_ready) got.push_back('{cyc, dout_hdr, dout_sop, dout_eop, dout_data});
    if (int'(dut.skid_count) > max_skid) max_skid = int'(dut.skid_count);
    if (hdr_rdreq) saw_rdreq = 1;
    if (wvb_rddone || hdr_rdreq) begin
      chk("rdreq_with_rddone", hdr_rdreq, wvb_rddone);
      chk("hdr_held_in_done", hdr_data, done_cnt < evt_hdrs.size() ? evt_hdrs[done_cnt] : '0);
      done_cnt++;
      pop_pend = hdr_rdreq;
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [HW-1:0] mk_hdr(input logic [AW-1:0] s, input logic [AW-1:0] t);
    return {16'($urandom), 32'($urandom), s, t, 8'($urandom)};
  endfunction
  // event model: words from start..stop inclusive, modulo buffer size
  task automatic expect_words(input logic [HW-1:0] h);
    logic [AW-1:0] s, t;
    int len;
    s = h[31:20];
    t = h[19:8];
    len = int'(AW'(t - s)) + 1;
    for (int i = 0; i < len; i++)
      exp_q.push_back('{0, h, i == 0, i == len - 1, ram[AW'(int'(s) + i)]});
  endtask
  task automatic add_event(input logic [AW-1:0] s, input logic [AW-1:0] t, output logic [HW-1:0] h);
    h = mk_hdr(s, t);
    hq.push_back(h);
    evt_hdrs.push_back(h);
    expect_words(h);
  endtask
  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("rddone_count", done_cnt, n);
  endtask
  task automatic compare(input string tag, input bit timing);
    chk({tag, "_nwords"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, {got[i].hdr, got[i].sop, got[i].eop, got[i].data},
          {exp_q[i].hdr, exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
    if (timing && got.size() > 0)
      chk({tag, "_rate"}, got[got.size()-1].cyc - got[0].cyc, exp_q.size() - 1);
    got.delete();
    exp_q.delete();
  endtask
  task automatic outs_zero(input string tag);
    chk({tag, "_ctrl"}, {hdr_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, busy}, 0);
    chk({tag, "_addr"}, wvb_rd_addr, 0);
    chk({tag, "_data"}, dout_data, 0);
    chk({tag, "_hdr"}, dout_hdr, 0);
  endtask
  initial begin
    logic [HW-1:0] h;
    logic [AW-1:0] s;
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst = 0;
    // readout held off: header waiting but nothing happens until rd_en
    add_event(12'h010, 12'h013, h);
    saw_rdreq = 0;
    repeat (10) @(negedge clk);
    chk("hold_rdreq", saw_rdreq, 0);
    chk("hold_busy", busy, 0);
    chk("hold_words", got.size(), 0);
    chk("hold_addr", wvb_rd_addr, 0);
    rd_en = 1;
    @(negedge clk);
    chk("load_next_cycle", busy, 1);
    wait_done(1, 100);
    compare("single", 1);
    // wrapping event, rd_en dropped once the event is under way
    add_event(12'hFFE, 12'h001, h);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    rd_en = 0;
    wait_done(2, 100);
    rd_en = 1;
    compare("wrap", 1);
    // full buffer
    add_event(12'h100, 12'h0FF, h);
    wait_done(3, 5000);
    compare("full", 1);
    // three queued events with random backpressure, one of them a single word
    rand_ready = 1;
    max_skid = 0;
    s = AW'($urandom);
    add_event(s, s, h);
    for (int e = 0; e < 2; e++) begin
      s = AW'($urandom);
      add_event(s, AW'(s + AW'($urandom_range(1, 60))), h);
    end
    wait_done(6, 3000);
    compare("random_ready", 0);
    chk("skid_bound", max_skid <= SD, 1);
    rand_ready = 0;
    // reset in the middle of an event: aborted, header kept, re-read from the start
    add_event(12'h200, 12'h2FF, h);
    for (int k = 0; k < 200 && got.size() < 20; k++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1 outs_zero("mid_reset");
    chk("mid_reset_hdr_kept", hq.size(), 1);
    chk("mid_reset_no_rddone", done_cnt, 6);
    got.delete();
    exp_q.delete();
    expect_words(h);
    @(negedge clk);
    #2 rst = 0;
    wait_done(7, 1000);
    compare("after_reset", 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
